// File: rtl/cpu_pkg.sv
// Shared constants, grant encoding and helpers for the write-back path.
// Optional build macro used by rf_wb_arb: RF_WB_BYPASS_EN.
package cpu_pkg;

  localparam int D_WIDTH = 32;
  localparam int N_REGS  = 32;
  localparam int REG_L2  = $clog2(N_REGS);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  localparam int IDX_ALU = 0;
  localparam int IDX_LSU = 1;

  typedef struct packed {
    logic [REG_L2-1:0]  rd;
    logic [D_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [N_REGS-1:0] rd_dec(
    input logic [REG_L2-1:0] rd
  );
    logic [N_REGS-1:0] v;
    v = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter, index 0 = ALU, index 1 = LSU.
// last_grant moves only on a grant; ALU wins the first tie after reset.
module wb_rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  gnt_e       r_last;
  logic [1:0] w_gnt;

  // Pick the single requester, or the one not granted last on a tie.
  always_comb begin
    w_gnt = 2'b00;
    unique case (req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = (r_last == GNT_LSU) ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
  end

  // Remember the winner of each completed transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_LSU;
    end else if (|w_gnt) begin
      r_last <= w_gnt[IDX_LSU] ? GNT_LSU : GNT_ALU;
    end
  end

  assign gnt = w_gnt;

endmodule

// File: rtl/rf_wb_arb.sv
// Write-back arbiter plus pending-write scoreboard for the RF write port.
// RF_WB_BYPASS_EN adds combinational fwd_* copies of the registered write.
module rf_wb_arb
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_L2-1:0]  alu_rd,
  input  logic [D_WIDTH-1:0] alu_data,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [REG_L2-1:0]  lsu_rd,
  input  logic [D_WIDTH-1:0] lsu_data,
  input  logic               issue_vld,
  input  logic [REG_L2-1:0]  issue_rd,
  output logic [N_REGS-1:0]  pend_mask,
`ifdef RF_WB_BYPASS_EN
  output logic               fwd_vld,
  output logic [REG_L2-1:0]  fwd_addr,
  output logic [D_WIDTH-1:0] fwd_data,
`endif
  output logic               rf_we,
  output logic [REG_L2-1:0]  rf_w_addr,
  output logic [D_WIDTH-1:0] rf_w_data
);

  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_xfer;
  wb_req_t            w_win;
  logic               w_wr;
  logic [N_REGS-1:0]  w_clr;
  logic [N_REGS-1:0]  w_set;

  logic               r_we;
  logic [REG_L2-1:0]  r_addr;
  logic [D_WIDTH-1:0] r_data;
  logic [N_REGS-1:0]  r_pend;

  assign w_req = {lsu_valid, alu_valid};

  wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt)
  );

  assign alu_ready = w_gnt[IDX_ALU];
  assign lsu_ready = w_gnt[IDX_LSU];
  assign w_xfer    = |w_gnt;

  // Mux the winning producer and build scoreboard set/clear masks.
  always_comb begin
    w_win = '0;
    unique case (1'b1)
      w_gnt[IDX_LSU]: begin
        w_win.rd   = lsu_rd;
        w_win.data = lsu_data;
      end
      w_gnt[IDX_ALU]: begin
        w_win.rd   = alu_rd;
        w_win.data = alu_data;
      end
      default: w_win = '0;
    endcase
    w_wr  = w_xfer && (w_win.rd != '0);
    w_clr = w_xfer ? rd_dec(w_win.rd) : '0;
    w_set = '0;
    if (issue_vld && (issue_rd != '0)) begin
      w_set = rd_dec(issue_rd);
    end
  end

  // Register the RF write; x0 transfers complete without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr <= w_win.rd;
        r_data <= w_win.data;
      end
    end
  end

  // Pending bits: clear on write-back, set on issue; a same-edge set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign rf_we     = r_we;
  assign rf_w_addr = r_addr;
  assign rf_w_data = r_data;
  assign pend_mask = r_pend;

`ifdef RF_WB_BYPASS_EN
  assign fwd_vld  = r_we;
  assign fwd_addr = r_addr;
  assign fwd_data = r_data;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: vector table for arbitration, scoreboard queue
// for registered writes, hand sequences for pend_mask and async reset.
module tb_rf_wb_arb;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               alu_valid, alu_ready;
  logic [REG_L2-1:0]  alu_rd;
  logic [D_WIDTH-1:0] alu_data;
  logic               lsu_valid, lsu_ready;
  logic [REG_L2-1:0]  lsu_rd;
  logic [D_WIDTH-1:0] lsu_data;
  logic               issue_vld;
  logic [REG_L2-1:0]  issue_rd;
  logic [N_REGS-1:0]  pend_mask;
  logic               rf_we;
  logic [REG_L2-1:0]  rf_w_addr;
  logic [D_WIDTH-1:0] rf_w_data;
`ifdef RF_WB_BYPASS_EN
  logic               fwd_vld;
  logic [REG_L2-1:0]  fwd_addr;
  logic [D_WIDTH-1:0] fwd_data;
`endif

  rf_wb_arb dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .pend_mask (pend_mask),
`ifdef RF_WB_BYPASS_EN
    .fwd_vld   (fwd_vld),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
`endif
    .rf_we     (rf_we),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic        ear;
    logic        elr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] m_mask;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [4:0] ird,
    input logic ear, input logic elr
  );
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird;
    v.ear = ear; v.elr = elr;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    wr_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{we: 1'b0, addr: '0, data: '0};
    chk("rf_we", {63'd0, rf_we}, {63'd0, e.we});
    if (e.we) begin
      chk("rf_w_addr", {59'd0, rf_w_addr}, {59'd0, e.addr});
      chk("rf_w_data", {32'd0, rf_w_data}, {32'd0, e.data});
    end
    chk("pend_mask", {32'd0, pend_mask}, {32'd0, m_mask});
`ifdef RF_WB_BYPASS_EN
    chk("fwd_vld", {63'd0, fwd_vld}, {63'd0, e.we});
`endif
  endtask

  task automatic cycle(input vec_t v);
    wr_t e;
    @(negedge clk);
    check_regs();
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_vld = v.iv; issue_rd = v.ird;
    #1;
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, v.ear});
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, v.elr});
    e = '{we: 1'b0, addr: '0, data: '0};
    if (v.ear) e = '{we: (v.ard != 0), addr: v.ard, data: v.ad};
    else if (v.elr) e = '{we: (v.lrd != 0), addr: v.lrd, data: v.ld};
    sb.push_back(e);
    if (v.ear || v.elr) m_mask[e.addr] = 1'b0;
    if (v.iv && v.ird != 0) m_mask[v.ird] = 1'b1;
  endtask

  task automatic idle();
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  logic [31:0] saved;

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_vld = 0; issue_rd = 0;
    m_mask = '0;
    #2;
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    chk("rst_pend", {32'd0, pend_mask}, 64'd0);
    chk("rst_addr", {59'd0, rf_w_addr}, 64'd0);
    chk("rst_data", {32'd0, rf_w_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 0, 1));
    tbl.push_back(mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0000_1234, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 32'h3333_0003, 1, 4, 32'h4444_0004, 1, 20, 1, 0));
    tbl.push_back(mk(1, 10, 32'hA0A0_000A, 1, 11, 32'hB0B0_000B, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 12, 32'hC0C0_000C, 0, 0, 0, 1));
    tbl.push_back(mk(1, 13, 32'hD0D0_000D, 1, 14, 32'hE0E0_000E, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20, 32'h2020_2020, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) cycle(tbl[i]);

    // issue rd7, write it three cycles later
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
    @(posedge clk); #1;
    chk("pend7_set", {63'd0, pend_mask[7]}, 64'd1);
    idle();
    idle();
    cycle(mk(1, 7, 32'h7777_0007, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    chk("pend7_clr", {63'd0, pend_mask[7]}, 64'd0);
    chk("wb7_we", {63'd0, rf_we}, 64'd1);

    // same-edge issue and write-back of rd9: set wins
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
    cycle(mk(0, 0, 0, 1, 9, 32'h9999_0009, 1, 9, 0, 1));
    @(posedge clk); #1;
    chk("pend9_keep", {63'd0, pend_mask[9]}, 64'd1);
    cycle(mk(1, 9, 32'h9999_1111, 0, 0, 0, 0, 0, 1, 0));
    idle();

    // x0 write and x0 issue
    saved = m_mask;
    cycle(mk(0, 0, 0, 1, 0, 32'h0000_1234, 1, 0, 0, 1));
    @(posedge clk); #1;
    chk("x0_we", {63'd0, rf_we}, 64'd0);
    chk("x0_pend", {32'd0, pend_mask}, {32'd0, saved});

    // async reset right after a registered write
    cycle(mk(1, 4, 32'hCAFE_F00D, 0, 0, 0, 1, 6, 1, 0));
    @(posedge clk); #2;
    chk("pre_rst_we", {63'd0, rf_we}, 64'd1);
    alu_valid = 0; lsu_valid = 0; issue_vld = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {63'd0, rf_we}, 64'd0);
    chk("mid_rst_pend", {32'd0, pend_mask}, 64'd0);
    chk("mid_rst_addr", {59'd0, rf_w_addr}, 64'd0);
    chk("mid_rst_data", {32'd0, rf_w_data}, 64'd0);
    sb.delete();
    m_mask = '0;
    @(negedge clk);
    rst = 1'b0;
    // last_grant back to LSU: ALU wins the tie
    cycle(mk(1, 15, 32'h1515_1515, 1, 16, 32'h1616_1616, 0, 0, 1, 0));
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
